// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: combinational fetch lookup, execute-stage training, registered redirect.
// Define BP_PERF_EN to add perf_branches / perf_mispredicts event counters.
module branch_predictor #(
    parameter int unsigned ENTRIES    = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  upd_valid,
    input  logic                  upd_is_jump,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_pred_taken,
    input  logic [ADDR_WIDTH-1:0] upd_pred_target,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] flush_pc
`ifdef BP_PERF_EN
    ,
    output logic [31:0]           perf_branches,
    output logic [31:0]           perf_mispredicts
`endif
);

    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned TAG_LO = IDX_W + 2;
    localparam int unsigned TAG_HI = TAG_WIDTH + IDX_W + 1;

    typedef logic [CNT_WIDTH-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;
    localparam cnt_t CNT_WT  = cnt_t'(1) << (CNT_WIDTH - 1);
    localparam cnt_t CNT_WNT = cnt_t'(CNT_WT - cnt_t'(1));

    logic                  valid_q  [ENTRIES];
    logic [TAG_WIDTH-1:0]  tag_q    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
    cnt_t                  cnt_q    [ENTRIES];

    logic [IDX_W-1:0]      lk_idx;
    logic [TAG_WIDTH-1:0]  lk_tag;

    always_comb begin
        lk_idx      = if_pc[IDX_W+1:2];
        lk_tag      = if_pc[TAG_HI:TAG_LO];
        pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = pred_hit && cnt_q[lk_idx][CNT_WIDTH-1];
        pred_target = pred_taken ? target_q[lk_idx] : if_pc + ADDR_WIDTH'(4);
    end

    logic [IDX_W-1:0]      up_idx;
    logic [TAG_WIDTH-1:0]  up_tag;
    logic                  up_hit;
    logic                  eff_taken;
    logic                  tbl_we;
    cnt_t                  cnt_cur;
    cnt_t                  cnt_nxt;
    logic [ADDR_WIDTH-1:0] upd_fall;
    logic [ADDR_WIDTH-1:0] correct_pc;
    logic [ADDR_WIDTH-1:0] predicted_pc;
    logic                  mispredict;

    always_comb begin
        up_idx    = upd_pc[IDX_W+1:2];
        up_tag    = upd_pc[TAG_HI:TAG_LO];
        up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        eff_taken = upd_is_jump || upd_taken;
        tbl_we    = upd_valid && (up_hit || eff_taken);
        cnt_cur   = cnt_q[up_idx];
        cnt_nxt   = cnt_cur;
        // Jumps saturate high; fresh conditional allocations start weakly taken.
        if (upd_is_jump)
            cnt_nxt = CNT_MAX;
        else if (!up_hit)
            cnt_nxt = CNT_WT;
        else if (upd_taken)
            cnt_nxt = (cnt_cur == CNT_MAX) ? CNT_MAX : cnt_t'(cnt_cur + cnt_t'(1));
        else
            cnt_nxt = (cnt_cur == '0) ? '0 : cnt_t'(cnt_cur - cnt_t'(1));

        upd_fall     = upd_pc + ADDR_WIDTH'(4);
        correct_pc   = eff_taken ? upd_target : upd_fall;
        predicted_pc = upd_pred_taken ? upd_pred_target : upd_fall;
        mispredict   = upd_valid && (correct_pc != predicted_pc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WNT;
            end
        end else if (tbl_we) begin
            valid_q[up_idx] <= 1'b1;
            tag_q[up_idx]   <= up_tag;
            cnt_q[up_idx]   <= cnt_nxt;
            if (eff_taken)
                target_q[up_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush    <= 1'b0;
            flush_pc <= '0;
        end else begin
            flush <= mispredict;
            if (mispredict)
                flush_pc <= correct_pc;
        end
    end

`ifdef BP_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (upd_valid)
                perf_branches <= perf_branches + 32'd1;
            if (mispredict)
                perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: array-based reference model, randomized plus directed traffic.
module tb_branch_predictor;

    localparam int unsigned ENTRIES = 64;
    localparam int unsigned AW      = 32;
    localparam int unsigned TW      = 8;
    localparam int unsigned CW      = 2;
    localparam int          CMAX    = (1 << CW) - 1;
    localparam int          CWT     = 1 << (CW - 1);
    localparam int          CWNT    = CWT - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] if_pc;
    logic          pred_hit, pred_taken;
    logic [AW-1:0] pred_target;
    logic          upd_valid, upd_is_jump, upd_taken, upd_pred_taken;
    logic [AW-1:0] upd_pc, upd_target, upd_pred_target;
    logic          flush;
    logic [AW-1:0] flush_pc;
`ifdef BP_PERF_EN
    logic [31:0]   perf_branches, perf_mispredicts;
`endif

    branch_predictor #(
        .ENTRIES(ENTRIES), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_is_jump(upd_is_jump), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .flush(flush), .flush_pc(flush_pc)
`ifdef BP_PERF_EN
        , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic hit; logic taken; logic [31:0] target; } lk_t;
    typedef struct { logic fl; logic [31:0] fpc; logic [31:0] pb; logic [31:0] pm; } fl_t;

    lk_t lk_q[$];
    fl_t fl_q[$];
    lk_t me;
    fl_t mf;
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;

    // Reference model: plain arrays, counter kept as an integer in [0, CMAX].
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    logic [31:0] m_fpc, m_pb, m_pm;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc >> (2 + $clog2(ENTRIES))) % (1 << TW);
    endfunction

    function automatic lk_t predict(input logic [31:0] pc);
        lk_t r;
        int unsigned i;
        i        = idx_of(pc);
        r.hit    = m_valid[i] && (m_tag[i] == tag_of(pc));
        r.taken  = r.hit && (m_cnt[i] >= CWT);
        r.target = r.taken ? m_tgt[i] : pc + 32'd4;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 32'h0;
            m_cnt[i]   = CWNT;
        end
        m_fpc = 32'h0;
        m_pb  = 32'h0;
        m_pm  = 32'h0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [31:0] pc, input bit v, input bit jump,
                        input logic [31:0] upc, input bit tk, input logic [31:0] tgt,
                        input bit ptk, input logic [31:0] ptgt);
        fl_t         e;
        bit          eff, h, mis;
        logic [31:0] correct, predicted;
        int unsigned i;
        @(posedge clk);
        #2;
        if_pc = pc; upd_valid = v; upd_is_jump = jump; upd_pc = upc;
        upd_taken = tk; upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
        lk_q.push_back(predict(pc));
        eff       = jump | tk;
        correct   = eff ? tgt : upc + 32'd4;
        predicted = ptk ? ptgt : upc + 32'd4;
        mis       = v && (correct != predicted);
        if (v) m_pb = m_pb + 32'd1;
        if (mis) begin
            m_pm  = m_pm + 32'd1;
            m_fpc = correct;
        end
        e.fl = mis; e.fpc = m_fpc; e.pb = m_pb; e.pm = m_pm;
        fl_q.push_back(e);
        if (v) begin
            i = idx_of(upc);
            h = m_valid[i] && (m_tag[i] == tag_of(upc));
            if (h) begin
                if (jump)     m_cnt[i] = CMAX;
                else if (eff) m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
                else          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
                if (eff) m_tgt[i] = tgt;
            end else if (eff) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(upc);
                m_tgt[i]   = tgt;
                m_cnt[i]   = jump ? CMAX : CWT;
            end
        end
    endtask

    function automatic logic [31:0] pick_pc();
        logic [7:0]  tg;
        logic [15:0] hi;
        if ($urandom_range(0, 11) == 0) return 32'hFFFF_FFFC;
        case ($urandom_range(0, 3))
            0: tg = 8'h00;
            1: tg = 8'h01;
            2: tg = 8'h11;
            default: tg = 8'h22;
        endcase
        hi = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
        return {hi, tg, 6'($urandom_range(0, 7)), 2'b00};
    endfunction

    task automatic rand_step();
        logic [31:0] pc, upc, tgt, ptgt;
        bit          v, jump, tk, ptk;
        lk_t         p;
        pc   = pick_pc();
        upc  = pick_pc();
        v    = ($urandom_range(0, 9) < 7);
        jump = ($urandom_range(0, 4) == 0);
        tk   = ($urandom_range(0, 1) == 1);
        tgt  = ($urandom_range(0, 3) == 0) ? $urandom : {16'h0, 14'($urandom), 2'b00};
        if ($urandom_range(0, 9) < 7) begin
            p    = predict(upc);
            ptk  = p.taken;
            ptgt = p.target;
        end else begin
            ptk  = ($urandom_range(0, 1) == 1);
            ptgt = ($urandom_range(0, 1) == 1) ? tgt : upc + 32'd4;
        end
        step(pc, v, jump, upc, tk, tgt, ptk, ptgt);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (lk_q.size() > 0) begin
                me = lk_q.pop_front();
                check("pred_hit", {31'h0, pred_hit}, {31'h0, me.hit});
                check("pred_taken", {31'h0, pred_taken}, {31'h0, me.taken});
                check("pred_target", pred_target, me.target);
            end
            if (fl_q.size() >= 2) begin
                mf = fl_q.pop_front();
                check("flush", {31'h0, flush}, {31'h0, mf.fl});
                check("flush_pc", flush_pc, mf.fpc);
`ifdef BP_PERF_EN
                check("perf_branches", perf_branches, mf.pb);
                check("perf_mispredicts", perf_mispredicts, mf.pm);
`endif
            end
        end
    end

    task automatic release_reset();
        model_reset();
        fl_q.delete();
        lk_q.delete();
        fl_q.push_back('{1'b0, 32'h0, 32'h0, 32'h0});
        mon_en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; if_pc = 32'h100;
        upd_valid = 1'b0; upd_is_jump = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
        #1;
        check("rst_hit", {31'h0, pred_hit}, 32'h0);
        check("rst_taken", {31'h0, pred_taken}, 32'h0);
        check("rst_target", pred_target, 32'h104);
        check("rst_flush", {31'h0, flush}, 32'h0);
        check("rst_flush_pc", flush_pc, 32'h0);
        @(posedge clk); #2;
        rst = 1'b0;
        release_reset();

        // Cold branch, flush pulse, then hit.
        step(32'h100, 1, 0, 32'h100, 1, 32'h200, 0, 32'h104);
        step(32'h100, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        step(32'h100, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        // Training down, back up, then saturation.
        step(32'h100, 1, 0, 32'h100, 0, 32'h0, 1, 32'h200);
        step(32'h100, 1, 0, 32'h100, 0, 32'h0, 0, 32'h104);
        step(32'h100, 1, 0, 32'h100, 1, 32'h200, 0, 32'h104);
        step(32'h100, 1, 0, 32'h100, 1, 32'h200, 0, 32'h104);
        for (int k = 0; k < 4; k++)
            step(32'h100, 1, 0, 32'h100, 1, 32'h200, 1, 32'h200);
        // Alias at same index, different tag.
        step(32'h1100, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        step(32'h1100, 1, 0, 32'h1100, 1, 32'h1800, 0, 32'h1104);
        step(32'h100, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        step(32'h1100, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        // Same-cycle read/write, then new target visible.
        step(32'h1100, 1, 0, 32'h1100, 1, 32'h2400, 1, 32'h1800);
        step(32'h1100, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        // jal on a miss, then wrap of +4.
        step(32'h300, 1, 1, 32'h300, 0, 32'h380, 0, 32'h304);
        step(32'h300, 1, 0, 32'h300, 0, 32'h0, 1, 32'h380);
        step(32'h300, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        step(32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h40);

        for (int k = 0; k < 400; k++) rand_step();

        // Reset while a flush is showing and an update is presented.
        step(32'h500, 1, 0, 32'h500, 1, 32'h900, 0, 32'h504);
        @(posedge clk); #2;
        check("flush_before_rst", {31'h0, flush}, {31'h0, fl_q[fl_q.size()-1].fl});
        mon_en = 1'b0;
        if_pc = 32'h600; upd_valid = 1'b1; upd_is_jump = 1'b0; upd_pc = 32'h600;
        upd_taken = 1'b1; upd_target = 32'h700; upd_pred_taken = 1'b0; upd_pred_target = 32'h604;
        rst = 1'b1;
        #1;
        check("midrst_flush", {31'h0, flush}, 32'h0);
        check("midrst_flush_pc", flush_pc, 32'h0);
        check("midrst_hit", {31'h0, pred_hit}, 32'h0);
`ifdef BP_PERF_EN
        check("midrst_perf_br", perf_branches, 32'h0);
        check("midrst_perf_mp", perf_mispredicts, 32'h0);
`endif
        @(posedge clk); #2;
        rst = 1'b0; upd_valid = 1'b0;
        #1;
        check("post_rst_no_alloc", {31'h0, pred_hit}, 32'h0);
        check("post_rst_flush", {31'h0, flush}, 32'h0);
        if_pc = 32'h500;
        #1;
        check("post_rst_cleared", {31'h0, pred_hit}, 32'h0);
        release_reset();

        for (int k = 0; k < 100; k++) rand_step();
        step(32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        step(32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
